xor_64: RTL and testbench



---
 rtl/xor_64.sv | 49 ++++
 tb/tb_xor_64.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/xor_64.sv
// Registered bitwise-XOR slice of the ALU datapath with zero, parity and
// population-count status flags, all captured on the same edge as the result.
module xor_64 #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             in_valid,
   output logic [WIDTH-1:0] Y,
   output logic             out_valid,
   output logic             zero,
   output logic             parity,
   output logic [CNT_W-1:0] popcnt
);

   logic [WIDTH-1:0] xor_c;
   logic [CNT_W-1:0] cnt_c;

   always_comb begin
      xor_c = A ^ B;
      cnt_c = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_c = cnt_c + CNT_W'(xor_c[i]);
      end
   end

   // Parity and zero come from the count itself, so they can never disagree with popcnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         Y         <= '0;
         out_valid <= 1'b0;
         zero      <= 1'b1;
         parity    <= 1'b0;
         popcnt    <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            Y      <= xor_c;
            popcnt <= cnt_c;
            parity <= cnt_c[0];
            zero   <= (cnt_c == '0);
         end
      end
   end

endmodule

// File: tb/tb_xor_64.sv
// Bench for xor_64: table vectors and hand sequences feed a scoreboard queue
// that a negedge monitor checks cycle by cycle, including held outputs.
module tb_xor_64;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] A;
   logic [63:0] B;
   logic        in_valid;
   logic [63:0] Y;
   logic        out_valid;
   logic        zero;
   logic        parity;
   logic [6:0]  popcnt;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;

   xor_64 #(.WIDTH(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .in_valid  (in_valid),
      .Y         (Y),
      .out_valid (out_valid),
      .zero      (zero),
      .parity    (parity),
      .popcnt    (popcnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] y;
      logic [6:0]  cnt;
      logic        par;
      logic        zro;
   } vec_t;

   typedef struct {
      int unsigned due;
      logic        is_rst;
      logic [63:0] y;
      logic [6:0]  cnt;
      logic        par;
      logic        zro;
   } exp_t;

   exp_t sbq[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   // Drive one cycle of stimulus just after the edge and queue what should appear next cycle.
   task automatic apply(input logic r, input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] ey, input logic [6:0] ec, input logic ep, input logic ez);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; in_valid = v; A = a; B = b;
      e.due = cyc + 1; e.is_rst = r; e.y = ey; e.cnt = ec; e.par = ep; e.zro = ez;
      if (r || v) sbq.push_back(e);
   endtask

   task automatic apply_model(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] y;
      y = a ^ b;
      apply(1'b0, 1'b1, a, b, y, 7'($countones(y)), ^y, (y == 64'd0));
   endtask

   task automatic idle(input logic [63:0] a, input logic [63:0] b);
      apply(1'b0, 1'b0, a, b, '0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: expected outputs are either a newly due entry or the held previous result.
   logic        have_ref = 1'b0;
   logic        m_ov;
   logic [63:0] m_y;
   logic [6:0]  m_cnt;
   logic        m_par;
   logic        m_zro;
   exp_t        m_e;

   always @(negedge clk) begin
      m_ov = 1'b0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         m_e = sbq.pop_front();
         have_ref = 1'b1;
         if (m_e.is_rst) begin
            m_y = '0; m_cnt = '0; m_par = 1'b0; m_zro = 1'b1;
         end else begin
            m_ov = 1'b1;
            m_y = m_e.y; m_cnt = m_e.cnt; m_par = m_e.par; m_zro = m_e.zro;
         end
      end
      if (have_ref) begin
         check("out_valid", 64'(out_valid), 64'(m_ov));
         check("Y",         Y,              m_y);
         check("popcnt",    64'(popcnt),    64'(m_cnt));
         check("parity",    64'(parity),    64'(m_par));
         check("zero",      64'(zero),      64'(m_zro));
      end
   end

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{64'h000000000000000F, 64'h00000000000000F0, 64'h00000000000000FF, 7'd8,  1'b0, 1'b0};
      tbl[1]  = '{64'h00000000000000FF, 64'h0000000000000000, 64'h00000000000000FF, 7'd8,  1'b0, 1'b0};
      tbl[2]  = '{64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 64'h1DD99DD11DD99DD1, 7'd36, 1'b0, 1'b0};
      tbl[3]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 7'd0,  1'b0, 1'b1};
      tbl[4]  = '{64'h0000000000000000, 64'h0000000000000000, 64'h0000000000000000, 7'd0,  1'b0, 1'b1};
      tbl[5]  = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 7'd64, 1'b0, 1'b0};
      tbl[6]  = '{64'h0000000000000001, 64'h0000000000000000, 64'h0000000000000001, 7'd1,  1'b1, 1'b0};
      tbl[7]  = '{64'h8000000000000000, 64'h0000000000000000, 64'h8000000000000000, 7'd1,  1'b1, 1'b0};
      tbl[8]  = '{64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'hFFFFFFFFFFFFFFFF, 7'd64, 1'b0, 1'b0};
      tbl[9]  = '{64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F00, 64'hFFFFFFFFFFFFFFF0, 7'd60, 1'b0, 1'b0};
      tbl[10] = '{64'h0000000000000007, 64'h0000000000000000, 64'h0000000000000007, 7'd3,  1'b1, 1'b0};

      // Two reset cycles with live, all-ones operands presented.
      rst = 1'b1; in_valid = 1'b1; A = '1; B = '1;
      sbq.push_back('{1, 1'b1, 64'd0, 7'd0, 1'b0, 1'b1});
      apply(1'b1, 1'b1, '1, '1, '0, '0, 1'b0, 1'b0);

      // Single isolated pulse, then hold.
      apply(1'b0, 1'b1, tbl[0].a, tbl[0].b, tbl[0].y, tbl[0].cnt, tbl[0].par, tbl[0].zro);
      idle('0, '0);
      idle(64'hDEADBEEF, 64'h1);

      // Remaining table back-to-back.
      for (int i = 1; i < 11; i++)
         apply(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].cnt, tbl[i].par, tbl[i].zro);

      // Idle with unknown operands: nothing may leak to the outputs.
      idle('x, 'x);
      idle('x, 'x);

      // Five back-to-back random pairs, then idle with random operands.
      for (int i = 0; i < 5; i++) apply_model({$urandom, $urandom}, {$urandom, $urandom});
      for (int i = 0; i < 3; i++) idle({$urandom, $urandom}, {$urandom, $urandom});

      // Mid-stream one-cycle reset; its operands must never reach Y.
      for (int i = 0; i < 3; i++) apply_model({$urandom, $urandom}, {$urandom, $urandom});
      apply(1'b1, 1'b1, 64'hFFFF0000FFFF0000, 64'h0, '0, '0, 1'b0, 1'b0);
      idle({$urandom, $urandom}, {$urandom, $urandom});
      apply_model(64'h0123456789ABCDEF, 64'h0);
      apply_model({$urandom, $urandom}, {$urandom, $urandom});
      for (int i = 0; i < 3; i++) idle({$urandom, $urandom}, {$urandom, $urandom});

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drain", 64'(sbq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
